// File: rtl/mnist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mnist_pkg
// Purpose  : Shared constants and types for the MNIST pixel input stage:
//            image geometry, binarization threshold, FIFO depth default,
//            packer state encoding and the FIFO word layout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mnist_pkg;

  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int PIX        = IMG_W * IMG_H;
  localparam int WORDS      = PIX / 8;
  localparam int THRESH     = 128;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pk_state_e;

  // One FIFO entry: frame markers travel alongside the packed byte.
  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [7:0] data;
  } word_t;

endpackage
`default_nettype wire

// File: rtl/mnist_pixel_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : mnist_pixel_packer_if
// Purpose  : Bundles the pixel-in and packed-word-out valid/ready streams.
// Ports    : s_valid/s_ready/s_data/s_sof  - byte-serial pixel stream
//            m_valid/m_ready/m_data/m_sof/m_eof - packed word stream
//            modport master : environment (drives pixels, consumes words)
//            modport slave  : the packer
// Revision : 1.0 - initial release
// ============================================================================
interface mnist_pixel_packer_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_sof;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_sof;
  logic       m_eof;

  modport master (
    output s_valid, s_data, s_sof, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_eof
  );

  modport slave (
    input  s_valid, s_data, s_sof, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_eof
  );
endinterface
`default_nettype wire

// File: rtl/mnist_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mnist_sync_fifo
// Purpose  : Small synchronous FIFO with occupancy counter. Output is the
//            head entry (zero when empty), stable until popped.
// Ports    : clk, rst (sync, active-high), push_i/din_i, pop_i,
//            full_o, empty_o, dout_o
// Revision : 1.0 - initial release
// ============================================================================
module mnist_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Gate stale storage so an empty FIFO presents all-zero output.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule
`default_nettype wire

// File: rtl/mnist_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : mnist_pixel_packer
// Purpose  : Binarizes a byte-serial grayscale frame, packs 8 pixels per
//            word (LSB = earliest pixel) and queues words with sof/eof.
// Ports    : clk, rst (sync, active-high)
//            bus   : mnist_pixel_packer_if.slave (pixel in / word out)
//            err_o : sticky frame-abort flag, cleared only by rst
// Revision : 1.0 - initial release
// ============================================================================
module mnist_pixel_packer #(
  parameter int IMG_W      = mnist_pkg::IMG_W,
  parameter int IMG_H      = mnist_pkg::IMG_H,
  parameter int THRESH     = mnist_pkg::THRESH,
  parameter int FIFO_DEPTH = mnist_pkg::FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  mnist_pixel_packer_if.slave  bus,
  output logic                 err_o
);
  import mnist_pkg::*;

  localparam int N_PIX = IMG_W * IMG_H;
  localparam int PCW   = $clog2(N_PIX);

  pk_state_e        state_q, state_d;
  logic [PCW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             err_q, err_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  word_t            push_word;
  word_t            head_word;
  logic             accept;
  logic             pix_bit;
  logic             last_pix;
  logic             sof_take;
  logic [7:0]       word;

  // Stall only when the pixel about to arrive would need a FIFO slot.
  assign bus.s_ready = !rst && !(fifo_full && bit_cnt_q == 3'd7);
  assign accept      = bus.s_valid && bus.s_ready;
  assign pix_bit     = (bus.s_data >= 8'(THRESH));
  assign last_pix    = (pix_cnt_q == PCW'(N_PIX - 1));
  assign word        = shift_q | (8'(pix_bit) << bit_cnt_q);
  // A marked pixel starts a frame from IDLE, or aborts a frame in progress.
  assign sof_take    = accept && bus.s_sof && (state_q == IDLE || pix_cnt_q != '0);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sof_take) state_d = RUN;
      RUN:     if (accept && !sof_take && last_pix) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / FIFO push logic.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    err_d     = err_q;
    push      = 1'b0;
    push_word = '0;
    if (sof_take) begin
      // Partial word of an aborted frame is dropped; this pixel is pixel 0.
      err_d     = err_q | (state_q == RUN);
      shift_d   = {7'd0, pix_bit};
      bit_cnt_d = 3'd1;
      pix_cnt_d = PCW'(1);
    end else if (accept && state_q == RUN) begin
      shift_d   = word;
      bit_cnt_d = bit_cnt_q + 3'd1;
      pix_cnt_d = last_pix ? '0 : pix_cnt_q + PCW'(1);
      if (bit_cnt_q == 3'd7) begin
        push      = 1'b1;
        shift_d   = '0;
        push_word = '{sof: (pix_cnt_q == PCW'(7)), eof: last_pix, data: word};
      end
    end
  end

  mnist_sync_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_word),
    .pop_i   (bus.m_valid && bus.m_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (head_word)
  );

  assign bus.m_valid = !fifo_empty;
  assign bus.m_data  = head_word.data;
  assign bus.m_sof   = head_word.sof;
  assign bus.m_eof   = head_word.eof;
  assign err_o       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_mnist_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mnist_pixel_packer
// Purpose  : Self-checking bench for mnist_pixel_packer. A pixel-level model
//            predicts packed words into a queue; a monitor pops and compares
//            each word the DUT hands out.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mnist_pixel_packer;
  localparam int PIX_N   = 784;
  localparam int WORDS_N = 98;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  int n_checks = 0;
  int n_pass   = 0;
  int acc_cnt  = 0;
  int rx_cnt   = 0;

  logic [9:0] exp_q [$];
  logic [9:0] rx_log [$];
  logic [9:0] mon_got;

  bit         m_in_frame = 1'b0;
  int         m_pix      = 0;
  logic [7:0] m_bits     = '0;
  logic       m_err      = 1'b0;
  logic [7:0] pre [8];
  bit         t6_done;

  mnist_pixel_packer_if bus ();

  mnist_pixel_packer dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .err_o (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_pix      = 0;
    m_bits     = '0;
    m_err      = 1'b0;
    exp_q.delete();
  endtask

  // Pixel-index model of the packer, applied to every accepted pixel.
  task automatic model_accept(input logic [7:0] d, input logic sof);
    if (sof && (!m_in_frame || m_pix != 0)) begin
      if (m_in_frame) m_err = 1'b1;
      m_in_frame = 1'b1;
      m_pix      = 0;
      m_bits     = '0;
    end
    if (m_in_frame) begin
      m_bits[m_pix % 8] = (d >= 8'd128);
      if (m_pix % 8 == 7) begin
        exp_q.push_back({m_pix == 7, m_pix == PIX_N - 1, m_bits});
        m_bits = '0;
      end
      m_pix++;
      if (m_pix == PIX_N) begin
        m_in_frame = 1'b0;
        m_pix      = 0;
      end
    end
  endtask

  // Monitor: a word transfers at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      mon_got = {bus.m_sof, bus.m_eof, bus.m_data};
      rx_cnt++;
      rx_log.push_back(mon_got);
      if (exp_q.size() == 0) check_eq("spurious_word", {22'd0, mon_got}, 32'h3ff_0000);
      else check_eq("word", {22'd0, mon_got}, {22'd0, exp_q.pop_front()});
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] d, input logic sof);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_sof   = sof;
    for (int w = 0; w <= 2000; w++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        model_accept(d, sof);
        acc_cnt++;
        @(posedge clk);
        #1;
        return;
      end
    end
    check_eq("s_ready_timeout", 0, 1);
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // kind 0: all 0xFF, 1: all 127, 2: random, 3: boundary prefix then random.
  task automatic send_frame(input int kind, input int npix);
    for (int i = 0; i < npix; i++) begin
      logic [7:0] d;
      case (kind)
        0:       d = 8'hFF;
        1:       d = 8'd127;
        default: d = 8'($urandom_range(0, 255));
      endcase
      if (kind == 3 && i < 8) d = pre[i];
      send_pix(d, i == 0);
    end
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.m_valid) return;
    end
    check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int         base;
    int         base_acc;
    int         n_sof;
    int         n_eof;
    logic [7:0] acc_or;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_sof   = 1'b0;
    bus.m_ready = 1'b1;
    pre = '{8'd127, 8'd128, 8'd0, 8'd255, 8'd129, 8'd1, 8'd200, 8'd50};
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_ready", bus.s_ready, 0);
    check_eq("rst_m_valid", bus.m_valid, 0);
    check_eq("rst_m_data", {bus.m_sof, bus.m_eof, bus.m_data}, 0);
    check_eq("rst_err", err, 0);
    settle(1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_s_ready", bus.s_ready, 1);
    settle(1);

    // Pixels without sof before any frame are dropped
    for (int i = 0; i < 20; i++) send_pix(8'(i * 13 + 128), 1'b0);
    bus.s_valid = 1'b0;
    settle(5);
    check_eq("idle_drop_words", rx_cnt, 0);
    check_eq("idle_drop_err", err, 0);

    // Full white frame
    base = rx_cnt;
    rx_log.delete();
    send_frame(0, PIX_N);
    wait_drain();
    check_eq("t1_words", rx_cnt - base, WORDS_N);
    check_eq("t1_first", rx_log[0], 10'h2FF);
    check_eq("t1_last", rx_log[WORDS_N - 1], 10'h1FF);
    check_eq("t1_err", err, 0);

    // Threshold boundary
    rx_log.delete();
    send_frame(3, PIX_N);
    wait_drain();
    check_eq("t2_word0", rx_log[0][7:0], 8'h5A);
    base = rx_cnt;
    rx_log.delete();
    send_frame(1, PIX_N);
    wait_drain();
    acc_or = '0;
    foreach (rx_log[i]) acc_or |= rx_log[i][7:0];
    check_eq("t2_all127_or", acc_or, 0);
    check_eq("t2_all127_words", rx_cnt - base, WORDS_N);

    // Backpressure: 4 words fill the FIFO, 40th pixel is held off
    bus.m_ready = 1'b0;
    base     = rx_cnt;
    base_acc = acc_cnt;
    fork
      send_frame(2, PIX_N);
      begin
        repeat (80) @(posedge clk);
        @(negedge clk);
        check_eq("t3_accepted", acc_cnt - base_acc, 39);
        check_eq("t3_s_ready", bus.s_ready, 0);
        check_eq("t3_m_valid", bus.m_valid, 1);
        check_eq("t3_no_rx", rx_cnt - base, 0);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
      end
    join
    wait_drain();
    check_eq("t3_words", rx_cnt - base, WORDS_N);

    // Abort at pixel 300
    base = rx_cnt;
    rx_log.delete();
    send_frame(2, 300);
    send_frame(2, PIX_N);
    wait_drain();
    n_sof = 0;
    n_eof = 0;
    foreach (rx_log[i]) begin
      n_sof += int'(rx_log[i][9]);
      n_eof += int'(rx_log[i][8]);
    end
    check_eq("t4_err", err, 1);
    check_eq("t4_err_model", err, m_err);
    check_eq("t4_words", rx_cnt - base, 37 + WORDS_N);
    check_eq("t4_sof_count", n_sof, 2);
    check_eq("t4_eof_count", n_eof, 1);

    // Reset pulse mid-frame
    send_frame(2, 400);
    rst = 1'b1;
    model_reset();
    settle(1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_m_valid", bus.m_valid, 0);
    check_eq("t5_err", err, 0);
    settle(1);
    base = rx_cnt;
    send_frame(2, PIX_N);
    wait_drain();
    check_eq("t5_words", rx_cnt - base, WORDS_N);
    check_eq("t5_err_after", err, 0);

    // Three back-to-back frames, toggling consumer from occupancy 3
    bus.m_ready = 1'b0;
    base     = rx_cnt;
    base_acc = acc_cnt;
    t6_done  = 1'b0;
    fork
      begin
        send_frame(2, PIX_N);
        send_frame(2, PIX_N);
        send_frame(2, PIX_N);
        t6_done = 1'b1;
      end
      begin
        for (int c = 0; c < 300 && (acc_cnt - base_acc) < 24; c++) settle(1);
        settle(2);
        check_eq("t6_occ3_valid", bus.m_valid, 1);
        check_eq("t6_occ3_ready", bus.s_ready, 1);
        check_eq("t6_occ3_no_rx", rx_cnt - base, 0);
        while (!t6_done) begin
          bus.m_ready = !bus.m_ready;
          settle(1);
        end
        bus.m_ready = 1'b1;
      end
    join
    wait_drain();
    check_eq("t6_words", rx_cnt - base, 3 * WORDS_N);
    check_eq("t6_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mnist_pixel_packer.md
Name: mnist_pixel_packer

Overview:
Upstream input stage of the MNIST accelerator. It accepts a byte-serial 28x28 grayscale pixel stream over a valid/ready handshake and binarizes each pixel against a threshold. It packs 8 binary pixels per output word and buffers the words in a small FIFO. The classifier core consumes the packed words over a second valid/ready handshake, with start-of-frame and end-of-frame markers.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels; IMG_W*IMG_H must be a multiple of 8
THRESH, 128, binarization threshold; bit = (pixel >= THRESH)
FIFO_DEPTH, 4, output FIFO depth in words; power of two, >= 2

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel ready
s_data  in  8  grayscale pixel, 0..255
s_sof  in  1  qualifies s_data as pixel 0 of a new frame
m_valid  out  1  packed word valid
m_ready  in  1  consumer ready
m_data  out  8  packed pixels; bit k = pixel (8*word_index + k), LSB first
m_sof  out  1  word is first of frame
m_eof  out  1  word is last of frame (word index WORDS-1)
err  out  1  sticky: frame aborted by premature s_sof; cleared only by rst

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Constants: PIX = IMG_W*IMG_H (784) and WORDS = PIX/8 (98). pix_cnt width is $clog2(PIX). bit_cnt is 3 bits.
- Reset (rst high at an edge) sets state=IDLE, pix_cnt=0, bit_cnt=0, shift register=0, FIFO empty, m_valid=0, m_sof=0, m_eof=0, m_data=0, err=0. s_ready=0 while rst is high.
- An input transfer occurs when s_valid && s_ready. An output transfer occurs when m_valid && m_ready.
- s_ready = !rst && !(fifo_full && bit_cnt==7). It depends only on registered full, with no pass-through: a pop in the same cycle does not raise s_ready.
- IDLE state:
  - Accepted pixels with s_sof=0 are discarded silently, with no err.
  - An accepted pixel with s_sof=1 becomes pixel 0 and the state moves to RUN.
- RUN state:
  - Each accepted pixel shifts its binarized bit into position bit_cnt; bit_cnt and pix_cnt increment.
  - When bit_cnt==7 and a pixel is accepted, push {sof=(pix_cnt==7), eof=(pix_cnt==PIX-1), data} into the FIFO and clear bit_cnt.
  - When pix_cnt==PIX-1 and a pixel is accepted, push the final word with eof=1, set pix_cnt=0, and return to IDLE.
- s_sof=1 on an accepted pixel while in RUN with pix_cnt!=0 is an abort:
  - Set err=1 and discard the partial word.
  - Words already pushed remain in the FIFO; no eof is emitted for the aborted frame.
  - The pixel is treated as pixel 0 of a new frame.
- s_sof on a non-accepted cycle is ignored.
- Latency: a packed word is visible on m_valid the cycle after its 8th pixel is accepted, provided the FIFO was empty.
- FIFO behaviour:
  - Simultaneous push and pop is allowed at any non-full occupancy; when full, a push cannot occur (s_ready is low).
  - Pop from an empty FIFO is impossible (m_valid=0).
  - Read and write pointers wrap modulo FIFO_DEPTH; an occupancy counter (width $clog2(FIFO_DEPTH)+1) distinguishes full from empty.
  - m_data, m_sof and m_eof are held stable while m_valid && !m_ready.
- Reset mid-frame discards all state and FIFO contents. The next edge after rst deasserts starts in IDLE.

Decomposition:
- Shared package mnist_pkg: IMG_W, IMG_H, PIX, WORDS, THRESH defaults, and the packer state enum (IDLE, RUN).
- One sub-module, mnist_sync_fifo: parameterized width (10 = {sof, eof, data[7:0]}) and depth, synchronous active-high rst, push/pop/full/empty/dout.

Test Plan:
1. Full frame of 784 pixels of 0xFF, s_sof on the first, m_ready=1 -> exactly 98 words of 0xFF; m_sof only on word 0, m_eof only on word 97, err=0.
2. Threshold boundary: frame starting with pixels 127,128,0,255,129,1,200,50 -> word 0 = 0x5A; an all-127 frame -> 98 words of 0x00.
3. Backpressure: m_ready=0 with continuous s_valid -> 4 words queued, then s_ready drops on the cycle the 40th pixel would complete word 5 (bit_cnt==7). Raise m_ready -> all 98 words arrive in order, and their contents match a reference model.
4. Abort: second s_sof at pixel 300 -> err=1; 37 words of the first frame emitted with no eof; the new frame yields 98 words with sof/eof; err stays 1.
5. Idle drop and reset:
   - 20 pixels with s_sof=0 before any frame -> no m_valid, err=0.
   - rst pulsed for 1 cycle at pixel 400 of a frame -> m_valid=0 and err=0 next cycle; a following clean frame yields 98 correct words.
6. Simultaneous push and pop at FIFO occupancy 3 with m_ready toggling every cycle -> no word lost or duplicated over 3 back-to-back frames.
